switch_matrix_cfg_loader: RTL and testbench

//  Serial configuration loader feeding one switch-matrix tile's route-select registers.
//  - Hunts a sync byte, then shifts in one 6-bit route word per matrix pin.
//  - Checks a CRC-8 and validates every word.
//  - Commits the shadow image to the flat cfg_out bus atomically; a failed frame leaves cfg_out untouched.

---
 rtl/matrix_cfg_pkg.sv | 52 +++++
 rtl/cfg_crc8_serial.sv | 40 ++++
 rtl/switch_matrix_cfg_loader.sv | 187 ++++++++++++++++++
 tb/tb_switch_matrix_cfg_loader.sv | 271 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/matrix_cfg_pkg.sv
// ---------------------------------------------------------------------------
// matrix_cfg_pkg
// Shared constants, types and helpers for the switch-matrix configuration
// loader: tile geometry, route-word layout, side codes, sync/CRC constants,
// the loader FSM state type and the route-word validity check.
// No ports (package).
// ---------------------------------------------------------------------------
package matrix_cfg_pkg;

    localparam int NTOP    = 5;
    localparam int NSIDE   = 4;
    localparam int ENTRY_W = 6;
    localparam int NENT    = 2 * NTOP + 2 * NSIDE;
    localparam int NBITS   = NENT * ENTRY_W;

    // Index limits in the width of the route word's index field.
    localparam logic [2:0] TOP_LIMIT  = 3'(NTOP);
    localparam logic [2:0] SIDE_LIMIT = 3'(NSIDE);

    localparam logic [2:0] SIDE_NONE   = 3'd0;
    localparam logic [2:0] SIDE_TOP    = 3'd1;
    localparam logic [2:0] SIDE_RIGHT  = 3'd2;
    localparam logic [2:0] SIDE_BOTTOM = 3'd3;
    localparam logic [2:0] SIDE_LEFT   = 3'd4;

    localparam logic [7:0] CFG_SYNC = 8'hA5;
    localparam logic [7:0] CRC_POLY = 8'h07;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        LOAD   = 2'd1,
        CHECK  = 2'd2,
        COMMIT = 2'd3
    } cfg_state_e;

    // A route word is legal when its source index exists on the named side.
    function automatic logic route_word_valid(input logic [ENTRY_W-1:0] word);
        logic [2:0] side;
        logic [2:0] idx;
        logic       ok;
        side = word[2:0];
        idx  = word[5:3];
        case (side)
            SIDE_NONE:               ok = 1'b1;
            SIDE_TOP,  SIDE_BOTTOM:  ok = (idx < TOP_LIMIT);
            SIDE_RIGHT, SIDE_LEFT:   ok = (idx < SIDE_LIMIT);
            default:                 ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/cfg_crc8_serial.sv
// ---------------------------------------------------------------------------
// cfg_crc8_serial
// Bit-serial CRC-8 (poly 0x07, init 0x00), one step per enabled cycle.
// Ports:
//   clk    in   clock, rising edge
//   rst    in   asynchronous active-high reset (crc -> 0)
//   clear  in   synchronous clear to the init value, wins over enable
//   enable in   advance the CRC by one bit
//   bit_in in   data bit
//   crc    out  current CRC register
// ---------------------------------------------------------------------------
module cfg_crc8_serial
    import matrix_cfg_pkg::*;
(
    input  logic       clk,
    input  logic       rst,
    input  logic       clear,
    input  logic       enable,
    input  logic       bit_in,
    output logic [7:0] crc
);

    logic fb_s;

    assign fb_s = crc[7] ^ bit_in;

    // CRC shift register: clear, step or hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            crc <= 8'h00;
        end else if (clear) begin
            crc <= 8'h00;
        end else if (enable) begin
            crc <= {crc[6:0], 1'b0} ^ (fb_s ? CRC_POLY : 8'h00);
        end else begin
            crc <= crc;
        end
    end

endmodule

// File: rtl/switch_matrix_cfg_loader.sv
// ---------------------------------------------------------------------------
// switch_matrix_cfg_loader
// Serial configuration loader for one switch-matrix tile. Hunts the sync
// byte, shifts one 6-bit route word per pin into a shadow image, checks a
// trailing CRC-8 and validates every word, then commits the image to
// cfg_out atomically. A rejected frame leaves cfg_out untouched.
// Ports:
//   clk        in   clock, rising edge
//   rst        in   asynchronous active-high reset
//   cfg_bit    in   serial config data
//   cfg_valid  in   cfg_bit qualifier
//   cfg_ready  out  bit accepted when cfg_valid & cfg_ready
//   cfg_clear  in   synchronous abort + zero the active config
//   cfg_out    out  active config, word k at [k*ENTRY_W +: ENTRY_W]
//   cfg_busy   out  frame in progress (LOAD or CHECK)
//   cfg_done   out  one-cycle pulse, frame committed
//   cfg_err    out  one-cycle pulse, frame rejected
// ---------------------------------------------------------------------------
module switch_matrix_cfg_loader
    import matrix_cfg_pkg::*;
(
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     cfg_bit,
    input  logic                     cfg_valid,
    output logic                     cfg_ready,
    input  logic                     cfg_clear,
    output logic [NENT*ENTRY_W-1:0]  cfg_out,
    output logic                     cfg_busy,
    output logic                     cfg_done,
    output logic                     cfg_err
);

    localparam logic [6:0] LAST_BIT = 7'(NBITS - 1);

    cfg_state_e         state_r;
    logic [7:0]         hunt_r;
    logic [NBITS-1:0]   shadow_r;
    logic [6:0]         bit_cnt_r;
    logic [2:0]         crc_cnt_r;
    logic [7:0]         rx_crc_r;
    logic [NBITS-1:0]   cfg_out_r;
    logic               ready_r;
    logic               busy_r;
    logic               done_r;
    logic               err_r;

    logic               accept_s;
    logic [7:0]         hunt_next_s;
    logic [7:0]         calc_crc_s;
    logic               all_valid_s;
    logic               frame_ok_s;
    logic               crc_clear_s;
    logic               crc_enable_s;

    assign accept_s     = cfg_valid & ready_r;
    assign hunt_next_s  = {hunt_r[6:0], cfg_bit};
    // The CRC sits at its init value for the whole of IDLE, so LOAD always
    // starts from 0x00 regardless of how the previous frame ended.
    assign crc_clear_s  = cfg_clear | (state_r == IDLE);
    assign crc_enable_s = accept_s & (state_r == LOAD);
    assign frame_ok_s   = (rx_crc_r == calc_crc_s) & all_valid_s;

    cfg_crc8_serial u_crc (
        .clk    (clk),
        .rst    (rst),
        .clear  (crc_clear_s),
        .enable (crc_enable_s),
        .bit_in (cfg_bit),
        .crc    (calc_crc_s)
    );

    // Validity of every route word in the shadow image (consumed only in COMMIT).
    always_comb begin
        all_valid_s = 1'b1;
        for (int k = 0; k < NENT; k++) begin
            if (!route_word_valid(shadow_r[k*ENTRY_W +: ENTRY_W])) begin
                all_valid_s = 1'b0;
            end else begin
                all_valid_s = all_valid_s;
            end
        end
    end

    // Loader FSM with all datapath registers and registered outputs.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_r   <= IDLE;
            hunt_r    <= 8'h00;
            shadow_r  <= '0;
            bit_cnt_r <= 7'd0;
            crc_cnt_r <= 3'd0;
            rx_crc_r  <= 8'h00;
            cfg_out_r <= '0;
            ready_r   <= 1'b1;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
        end else if (cfg_clear) begin
            // Abort from any state, including COMMIT: nothing is committed.
            state_r   <= IDLE;
            hunt_r    <= 8'h00;
            shadow_r  <= '0;
            bit_cnt_r <= 7'd0;
            crc_cnt_r <= 3'd0;
            rx_crc_r  <= 8'h00;
            cfg_out_r <= '0;
            ready_r   <= 1'b1;
            busy_r    <= 1'b0;
            done_r    <= 1'b0;
            err_r     <= 1'b0;
        end else begin
            done_r <= 1'b0;
            err_r  <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        hunt_r <= hunt_next_s;
                        if (hunt_next_s == CFG_SYNC) begin
                            state_r   <= LOAD;
                            busy_r    <= 1'b1;
                            bit_cnt_r <= 7'd0;
                        end else begin
                            state_r <= IDLE;
                        end
                    end else begin
                        hunt_r <= hunt_r;
                    end
                end
                LOAD: begin
                    // Sync patterns inside the data are just data here.
                    if (accept_s) begin
                        shadow_r[bit_cnt_r] <= cfg_bit;
                        if (bit_cnt_r == LAST_BIT) begin
                            state_r   <= CHECK;
                            bit_cnt_r <= 7'd0;
                            crc_cnt_r <= 3'd0;
                        end else begin
                            bit_cnt_r <= bit_cnt_r + 7'd1;
                        end
                    end else begin
                        bit_cnt_r <= bit_cnt_r;
                    end
                end
                CHECK: begin
                    if (accept_s) begin
                        rx_crc_r <= {rx_crc_r[6:0], cfg_bit};
                        if (crc_cnt_r == 3'd7) begin
                            state_r   <= COMMIT;
                            crc_cnt_r <= 3'd0;
                            ready_r   <= 1'b0;
                            busy_r    <= 1'b0;
                        end else begin
                            crc_cnt_r <= crc_cnt_r + 3'd1;
                        end
                    end else begin
                        crc_cnt_r <= crc_cnt_r;
                    end
                end
                COMMIT: begin
                    if (frame_ok_s) begin
                        cfg_out_r <= shadow_r;
                        done_r    <= 1'b1;
                    end else begin
                        err_r     <= 1'b1;
                    end
                    state_r <= IDLE;
                    hunt_r  <= 8'h00;
                    ready_r <= 1'b1;
                end
                default: begin
                    state_r <= IDLE;
                    hunt_r  <= 8'h00;
                    ready_r <= 1'b1;
                    busy_r  <= 1'b0;
                end
            endcase
        end
    end

    assign cfg_out   = cfg_out_r;
    assign cfg_ready = ready_r;
    assign cfg_busy  = busy_r;
    assign cfg_done  = done_r;
    assign cfg_err   = err_r;

endmodule

// File: tb/tb_switch_matrix_cfg_loader.sv
// ---------------------------------------------------------------------------
// tb_switch_matrix_cfg_loader
// Self-checking bench: frames are built as route-word images, serialised,
// and their expected outcome is pushed to a scoreboard queue; a monitor
// pops and compares whenever the loader pulses cfg_done or cfg_err.
// ---------------------------------------------------------------------------
module tb_switch_matrix_cfg_loader;

    localparam int NW = 18;
    localparam int NB = NW * 6;

    logic          clk;
    logic          rst;
    logic          cfg_bit;
    logic          cfg_valid;
    logic          cfg_ready;
    logic          cfg_clear;
    logic [NB-1:0] cfg_out;
    logic          cfg_busy;
    logic          cfg_done;
    logic          cfg_err;

    switch_matrix_cfg_loader dut (
        .clk       (clk),
        .rst       (rst),
        .cfg_bit   (cfg_bit),
        .cfg_valid (cfg_valid),
        .cfg_ready (cfg_ready),
        .cfg_clear (cfg_clear),
        .cfg_out   (cfg_out),
        .cfg_busy  (cfg_busy),
        .cfg_done  (cfg_done),
        .cfg_err   (cfg_err)
    );

    typedef struct {
        bit            ok;
        logic [NB-1:0] cfg;
        int            cyc;
    } exp_t;

    exp_t          sb_q[$];
    int            errors = 0;
    int            checks = 0;
    int            cyc = 0;
    int            gap_pct = 0;
    logic [NB-1:0] model_cfg = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // ---- reference model: spec rules in plain arithmetic ----
    function automatic logic [7:0] model_crc(input logic [NB-1:0] img);
        logic [7:0] c;
        logic       fb;
        c = 8'h00;
        for (int n = 0; n < NB; n++) begin
            fb = c[7] ^ img[n];
            c  = {c[6:0], 1'b0} ^ (fb ? 8'h07 : 8'h00);
        end
        return c;
    endfunction

    function automatic bit model_valid(input logic [NB-1:0] img);
        int w, side, idx;
        bit ok;
        ok = 1'b1;
        for (int k = 0; k < NW; k++) begin
            w    = int'(img[k*6 +: 6]);
            side = w % 8;
            idx  = w / 8;
            if (side == 0)                       ok = ok;
            else if (side == 1 || side == 3)     ok = ok && (idx < 5);
            else if (side == 2 || side == 4)     ok = ok && (idx < 4);
            else                                 ok = 1'b0;
        end
        return ok;
    endfunction

    // ---- stimulus ----
    task automatic send_bit(input logic b);
        int   guard;
        logic acc;
        guard = 0;
        while (gap_pct > 0 && int'($urandom_range(99)) < gap_pct && guard < 20) begin
            cfg_valid = 1'b0;
            @(posedge clk); #1;
            guard++;
        end
        cfg_valid = 1'b1;
        cfg_bit   = b;
        acc       = 1'b0;
        guard     = 0;
        while (!acc && guard < 100) begin
            @(negedge clk);
            acc = cfg_ready;
            @(posedge clk); #1;
            guard++;
        end
        if (!acc) begin
            checks++;
            errors++;
            $display("FAIL accept_timeout: got ready=0 expected ready=1 within 100 cycles");
        end
    endtask

    // Sends lead zeros, sync, the first n_data data bits and, for a full
    // data section, the first n_crc CRC bits (CRC xor'd with crc_xor).
    task automatic send_frame(input logic [NB-1:0] img, input logic [7:0] crc_xor,
                              input int n_data, input int n_crc, input int lead);
        logic [7:0] sync;
        logic [7:0] crc;
        exp_t       e;
        sync = 8'hA5;
        crc  = model_crc(img) ^ crc_xor;
        for (int i = 0; i < lead; i++) send_bit(1'b0);
        for (int i = 7; i >= 0; i--) send_bit(sync[i]);
        for (int n = 0; n < n_data; n++) send_bit(img[n]);
        if (n_data == NB) begin
            for (int i = 0; i < n_crc; i++) send_bit(crc[7-i]);
            if (n_crc == 8) begin
                e.ok  = (crc_xor == 8'h00) && model_valid(img);
                if (e.ok) model_cfg = img;
                e.cfg = model_cfg;
                e.cyc = cyc + 1;
                sb_q.push_back(e);
            end
        end
        cfg_valid = 1'b0;
    endtask

    function automatic logic [NB-1:0] rand_image();
        logic [NB-1:0] img;
        logic [2:0]    side;
        logic [2:0]    idx;
        for (int k = 0; k < NW; k++) begin
            if ($urandom_range(9) < 8) begin
                side = 3'($urandom_range(4));
                if (side == 3'd1 || side == 3'd3) idx = 3'($urandom_range(4));
                else                              idx = 3'($urandom_range(3));
                img[k*6 +: 6] = {idx, side};
            end else begin
                img[k*6 +: 6] = 6'($urandom);
            end
        end
        return img;
    endfunction

    // ---- monitor ----
    always @(negedge clk) begin
        exp_t e;
        if (!rst && (cfg_done || cfg_err)) begin
            if (sb_q.size() == 0) begin
                chk("unexpected_pulse", {126'd0, cfg_done, cfg_err}, 128'd0);
            end else begin
                e = sb_q.pop_front();
                chk("done",    {127'd0, cfg_done}, {127'd0, e.ok});
                chk("err",     {127'd0, cfg_err},  {127'd0, !e.ok});
                chk("cfg_out", 128'(cfg_out),      128'(e.cfg));
                chk("latency", 128'(cyc),          128'(e.cyc));
            end
        end
    end

    task automatic check_idle_outputs(input string tag, input logic [NB-1:0] exp_cfg);
        chk({tag, "_ready"},   {127'd0, cfg_ready}, {127'd0, 1'b1});
        chk({tag, "_busy"},    {127'd0, cfg_busy},  128'd0);
        chk({tag, "_done"},    {127'd0, cfg_done},  128'd0);
        chk({tag, "_err"},     {127'd0, cfg_err},   128'd0);
        chk({tag, "_cfg_out"}, 128'(cfg_out),       128'(exp_cfg));
    endtask

    task automatic drain();
        int guard;
        guard = 0;
        while (sb_q.size() != 0 && guard < 50) begin
            @(posedge clk); #1;
            guard++;
        end
        chk("scoreboard_drain", 128'(sb_q.size()), 128'd0);
    endtask

    logic [NB-1:0] img2;
    logic [NB-1:0] img;

    initial begin
        rst       = 1'b1;
        cfg_bit   = 1'b0;
        cfg_valid = 1'b0;
        cfg_clear = 1'b0;
        repeat (3) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        check_idle_outputs("reset", '0);
        @(posedge clk); #1;

        // 1: all-zero image, CRC 0x00
        send_frame('0, 8'h00, NB, 8, 2);
        drain();

        // 2: word0 = bottom[1]
        img2 = '0;
        img2[5:0] = 6'b001_011;
        send_frame(img2, 8'h00, NB, 8, 0);
        drain();
        chk("t2_word0", 128'(cfg_out[5:0]), 128'(6'h0B));

        // 3: same frame, CRC bit 0 flipped
        send_frame(img2, 8'h01, NB, 8, 1);
        drain();
        @(negedge clk);
        chk("t3_busy", {127'd0, cfg_busy}, 128'd0);

        // 4: invalid words with correct CRC
        img = '0;
        img[10*6 +: 6] = 6'b101_100;
        send_frame(img, 8'h00, NB, 8, 0);
        img = '0;
        img[5:0] = 6'b000_111;
        send_frame(img, 8'h00, NB, 8, 0);
        drain();

        // 5: clear at data bit 50 with a loaded image
        img = rand_image();
        send_frame(img, 8'h00, 50, 0, 0);
        cfg_clear = 1'b1;
        @(posedge clk); #1;
        cfg_clear = 1'b0;
        model_cfg = '0;
        check_idle_outputs("clear", '0);
        repeat (4) @(posedge clk); #1;
        send_frame(img2, 8'h00, NB, 8, 0);
        drain();

        // 6: random gaps, reset mid-CHECK, then the same frame gapped
        gap_pct = 50;
        send_frame(img2, 8'h00, NB, 4, 0);
        rst = 1'b1;
        model_cfg = '0;
        #2;
        check_idle_outputs("rst_mid", '0);
        @(posedge clk); #1;
        rst = 1'b0;
        send_frame(img2, 8'h00, NB, 8, 1);
        drain();

        // random frames, some corrupted, with and without gaps
        for (int f = 0; f < 12; f++) begin
            gap_pct = ($urandom_range(1) == 1) ? 50 : 0;
            img = rand_image();
            send_frame(img, ($urandom_range(4) == 0) ? 8'(1 << $urandom_range(7)) : 8'h00,
                       NB, 8, int'($urandom_range(3)));
        end
        drain();

        repeat (3) @(posedge clk);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
